// File: rtl/axis_byte_serializer_if.sv
// Stream bundle for axis_byte_serializer: the upstream word stream and the
// downstream byte stream. The slave modport is the serializer's view; the
// master modport is the view of whatever drives words in and sinks bytes out.
interface axis_byte_serializer_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [7:0]            m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
endinterface

// File: rtl/axis_byte_serializer.sv
// Word-to-byte AXI-Stream serializer. Each accepted WORD_WIDTH word is sent
// MSB-first as WORD_WIDTH/8 bytes, tlast on the final byte. A new word can be
// taken on the same edge the last byte leaves, so back-to-back words stream
// with no bubble.
module axis_byte_serializer #(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        arstn,
  axis_byte_serializer_if.slave       bus
);

  localparam int unsigned NUM_BYTES = WORD_WIDTH / 8;
  localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
  logic                  on_last;
  logic                  s_ready;
  logic                  word_hs;
  logic                  byte_hs;

  // Output-side decodes; all outputs except s_ready come straight from state
  assign on_last           = (state == SEND) && (cnt == LAST_IDX);
  assign byte_hs           = (state == SEND) && bus.m_axis_tready;
  // arstn gates ready so it is low during reset and rises as soon as reset lifts
  assign s_ready           = arstn && ((state == IDLE) || (on_last && bus.m_axis_tready));
  assign word_hs           = bus.s_axis_tvalid && s_ready;

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = (state == SEND);
  assign bus.m_axis_tlast  = on_last;
  assign bus.m_axis_tdata  = shreg[WORD_WIDTH-1 -: 8];

  // State, byte index and shift register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Next-state: load on word handshake, shift on byte handshake
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    unique case (state)
      IDLE: begin
        if (word_hs) begin
          shreg_nxt = bus.s_axis_tdata;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (byte_hs) begin
          if (!on_last) begin
            shreg_nxt = shreg << 8;
            cnt_nxt   = cnt + CNT_W'(1);
          end else if (word_hs) begin
            shreg_nxt = bus.s_axis_tdata;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Bench for axis_byte_serializer: a 24-bit instance for the directed and
// random scenarios, and an 8-bit instance for the one-byte-per-word case.
// Accepted words are expanded into expected bytes on a queue; a monitor pops
// and compares whenever a byte handshake occurs.
module tb_axis_byte_serializer;

  logic clk;
  logic arstn;

  int checks = 0;
  int errors = 0;
  int words_a = 0;
  int tlast_a = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  axis_byte_serializer_if #(.WORD_WIDTH(24)) a_if ();
  axis_byte_serializer_if #(.WORD_WIDTH(8))  b_if ();

  axis_byte_serializer #(.WORD_WIDTH(24)) dut_a (
    .clk   (clk),
    .arstn (arstn),
    .bus   (a_if.slave)
  );

  axis_byte_serializer #(.WORD_WIDTH(8)) dut_b (
    .clk   (clk),
    .arstn (arstn),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bytes come from the words the bench drove when they were accepted
  always @(negedge clk) begin
    if (a_if.s_axis_tvalid && a_if.s_axis_tready) begin
      qa.push_back({1'b0, a_if.s_axis_tdata[23:16]});
      qa.push_back({1'b0, a_if.s_axis_tdata[15:8]});
      qa.push_back({1'b1, a_if.s_axis_tdata[7:0]});
      words_a++;
    end
    if (b_if.s_axis_tvalid && b_if.s_axis_tready)
      qb.push_back({1'b1, b_if.s_axis_tdata});
  end

  // Byte monitors
  always @(negedge clk) begin
    if (a_if.m_axis_tvalid && a_if.m_axis_tready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a: unexpected byte %0h last %0b", a_if.m_axis_tdata, a_if.m_axis_tlast);
      end else begin
        logic [8:0] e;
        e = qa.pop_front();
        if ({a_if.m_axis_tlast, a_if.m_axis_tdata} !== e) begin
          errors++;
          $display("FAIL mon_a: got last/data %0b/%0h expected %0b/%0h",
                   a_if.m_axis_tlast, a_if.m_axis_tdata, e[8], e[7:0]);
        end
      end
      if (a_if.m_axis_tlast) tlast_a++;
    end
    if (b_if.m_axis_tvalid && b_if.m_axis_tready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b: unexpected byte %0h", b_if.m_axis_tdata);
      end else begin
        logic [8:0] e;
        e = qb.pop_front();
        if ({b_if.m_axis_tlast, b_if.m_axis_tdata} !== e) begin
          errors++;
          $display("FAIL mon_b: got last/data %0b/%0h expected %0b/%0h",
                   b_if.m_axis_tlast, b_if.m_axis_tdata, e[8], e[7:0]);
        end
      end
    end
  end

  // Returns just after the edge on which the pending word was accepted
  task automatic wait_accept_a(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_if.s_axis_tready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s: word not accepted within 50 cycles", name);
    end
    checks++;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte_a(input string name, input logic [7:0] data, input logic last);
    @(negedge clk);
    chk({name, "_valid"}, 32'(a_if.m_axis_tvalid), 32'd1);
    chk({name, "_data"},  32'(a_if.m_axis_tdata),  32'(data));
    chk({name, "_last"},  32'(a_if.m_axis_tlast),  32'(last));
  endtask

  task automatic expect_idle_a(input string name);
    @(negedge clk);
    chk({name, "_idle"}, 32'(a_if.m_axis_tvalid), 32'd0);
  endtask

  task automatic drain_a(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && !a_if.m_axis_tvalid) break;
    end
    chk({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0;
    a_if.s_axis_tdata  = '0;
    a_if.s_axis_tvalid = 1'b1;
    a_if.m_axis_tready = 1'b1;
    b_if.s_axis_tdata  = '0;
    b_if.s_axis_tvalid = 1'b0;
    b_if.m_axis_tready = 1'b1;

    // Reset values, with s_axis_tvalid high to show ready is held off
    #2;
    chk("rst_tvalid", 32'(a_if.m_axis_tvalid), 32'd0);
    chk("rst_tlast",  32'(a_if.m_axis_tlast),  32'd0);
    chk("rst_tdata",  32'(a_if.m_axis_tdata),  32'd0);
    chk("rst_sready", 32'(a_if.s_axis_tready), 32'd0);
    chk("rst_b_tvalid", 32'(b_if.m_axis_tvalid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_if.s_axis_tvalid = 1'b0;
    arstn = 1'b1;
    #1;
    chk("rel_sready_a", 32'(a_if.s_axis_tready), 32'd1);
    chk("rel_sready_b", 32'(b_if.s_axis_tready), 32'd1);

    // Single word, ready held high
    a_if.s_axis_tdata  = 24'hA1B2C3;
    a_if.s_axis_tvalid = 1'b1;
    wait_accept_a("single_acc");
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("single_b0", 8'hA1, 1'b0);
    expect_byte_a("single_b1", 8'hB2, 1'b0);
    expect_byte_a("single_b2", 8'hC3, 1'b1);
    expect_idle_a("single_end");

    // Back-to-back words with no bubble
    a_if.s_axis_tdata  = 24'h010203;
    a_if.s_axis_tvalid = 1'b1;
    wait_accept_a("b2b_acc");
    a_if.s_axis_tdata  = 24'h0A0B0C;
    expect_byte_a("b2b_01", 8'h01, 1'b0);
    chk("b2b_sready_mid", 32'(a_if.s_axis_tready), 32'd0);
    expect_byte_a("b2b_02", 8'h02, 1'b0);
    expect_byte_a("b2b_03", 8'h03, 1'b1);
    chk("b2b_sready_last", 32'(a_if.s_axis_tready), 32'd1);
    @(posedge clk); #1;
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("b2b_0a", 8'h0A, 1'b0);
    expect_byte_a("b2b_0b", 8'h0B, 1'b0);
    expect_byte_a("b2b_0c", 8'h0C, 1'b1);
    expect_idle_a("b2b_end");

    // Downstream stall while B2 is presented; upstream data wiggles meanwhile
    a_if.s_axis_tdata  = 24'hA1B2C3;
    a_if.s_axis_tvalid = 1'b1;
    wait_accept_a("stall_acc");
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("stall_a1", 8'hA1, 1'b0);
    @(posedge clk); #1;
    a_if.m_axis_tready = 1'b0;
    a_if.s_axis_tvalid = 1'b1;
    a_if.s_axis_tdata  = 24'h111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data",   32'(a_if.m_axis_tdata),  32'hB2);
      chk("stall_valid",  32'(a_if.m_axis_tvalid), 32'd1);
      chk("stall_last",   32'(a_if.m_axis_tlast),  32'd0);
      chk("stall_sready", 32'(a_if.s_axis_tready), 32'd0);
      @(posedge clk); #1;
      a_if.s_axis_tdata = a_if.s_axis_tdata + 24'h111111;
    end
    a_if.s_axis_tdata  = 24'h445566;
    a_if.m_axis_tready = 1'b1;
    expect_byte_a("stall_b2", 8'hB2, 1'b0);
    expect_byte_a("stall_c3", 8'hC3, 1'b1);
    chk("stall_sready_last", 32'(a_if.s_axis_tready), 32'd1);
    @(posedge clk); #1;
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("stall_44", 8'h44, 1'b0);
    expect_byte_a("stall_55", 8'h55, 1'b0);
    expect_byte_a("stall_66", 8'h66, 1'b1);
    expect_idle_a("stall_end");

    // Reset mid-word: remaining byte is discarded
    a_if.s_axis_tdata  = 24'hA1B2C3;
    a_if.s_axis_tvalid = 1'b1;
    wait_accept_a("rst_acc");
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("midrst_a1", 8'hA1, 1'b0);
    expect_byte_a("midrst_b2", 8'hB2, 1'b0);
    #2;
    arstn = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(a_if.m_axis_tvalid), 32'd0);
    chk("midrst_tlast",  32'(a_if.m_axis_tlast),  32'd0);
    chk("midrst_tdata",  32'(a_if.m_axis_tdata),  32'd0);
    chk("midrst_sready", 32'(a_if.s_axis_tready), 32'd0);
    qa.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    arstn = 1'b1;
    #1;
    chk("midrst_rel_sready", 32'(a_if.s_axis_tready), 32'd1);
    expect_idle_a("midrst_idle0");
    expect_idle_a("midrst_idle1");
    @(posedge clk); #1;
    a_if.s_axis_tdata  = 24'h112233;
    a_if.s_axis_tvalid = 1'b1;
    wait_accept_a("post_rst_acc");
    a_if.s_axis_tvalid = 1'b0;
    expect_byte_a("post_rst_11", 8'h11, 1'b0);
    expect_byte_a("post_rst_22", 8'h22, 1'b0);
    expect_byte_a("post_rst_33", 8'h33, 1'b1);
    expect_idle_a("post_rst_end");

    // Random valid/ready traffic
    words_a = 0;
    tlast_a = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      a_if.m_axis_tready = ($urandom_range(0, 3) != 0);
      a_if.s_axis_tvalid = ($urandom_range(0, 1) != 0);
      a_if.s_axis_tdata  = 24'($urandom);
    end
    @(posedge clk); #1;
    a_if.s_axis_tvalid = 1'b0;
    a_if.m_axis_tready = 1'b1;
    drain_a("rand");
    chk("rand_tlast_count", 32'(tlast_a), 32'(words_a));

    // 8-bit instance: one word per cycle, tlast on every byte
    @(posedge clk); #1;
    b_if.s_axis_tdata  = 8'h5A;
    b_if.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("w8_valid", 32'(b_if.m_axis_tvalid), 32'd1);
        chk("w8_data",  32'(b_if.m_axis_tdata),  32'h5A + 32'(i - 1));
        chk("w8_last",  32'(b_if.m_axis_tlast),  32'd1);
      end
      if (i < 4)
        chk("w8_sready", 32'(b_if.s_axis_tready), 32'd1);
      @(posedge clk); #1;
      if (i < 3) b_if.s_axis_tdata = 8'h5A + 8'(i + 1);
      else       b_if.s_axis_tvalid = 1'b0;
    end
    @(negedge clk);
    chk("w8_idle", 32'(b_if.m_axis_tvalid), 32'd0);
    chk("w8_queue_empty", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_byte_serializer.md
AXIS_BYTE_SERIALIZER -- requirements
Module: axis_byte_serializer

Interface
REQ-001 SHALL provide parameter WORD_WIDTH, default 16: input word width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL derive localparam NUM_BYTES = WORD_WIDTH/8: number of bytes emitted per word.
REQ-003 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have arstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have s_axis_tdata, input, WORD_WIDTH bits: word from the processor's master stream.
REQ-006 SHALL have s_axis_tvalid, input, 1 bit: upstream word valid.
REQ-007 SHALL have s_axis_tready, output, 1 bit: serializer can accept a word.
REQ-008 SHALL have m_axis_tdata, output, 8 bits: current byte toward the host transport.
REQ-009 SHALL have m_axis_tvalid, output, 1 bit: byte valid.
REQ-010 SHALL have m_axis_tready, input, 1 bit: downstream accepts byte.
REQ-011 SHALL have m_axis_tlast, output, 1 bit: marks the final byte of each word.

Function
REQ-012 SHALL define a word handshake as s_axis_tvalid && s_axis_tready, and a byte handshake as m_axis_tvalid && m_axis_tready, both sampled at a rising clk edge.
REQ-013 SHALL implement two states: IDLE (no word held) and SEND (word held, byte on output).
REQ-014 SHALL hold the word in a WORD_WIDTH shift register with a byte index cnt of width max(1, clog2(NUM_BYTES)).
REQ-015 SHALL emit bytes MSB-first: m_axis_tdata is always the top byte of the shift register.
REQ-016 SHALL drive m_axis_tvalid high exactly when in SEND, registered with no combinational path from s_axis inputs.
REQ-017 SHALL drive m_axis_tlast = (state==SEND && cnt==NUM_BYTES-1), and low otherwise.
REQ-018 SHALL drive s_axis_tready = (state==IDLE) || (byte handshake on the last byte); in the second case the only combinational dependency is on m_axis_tready.
REQ-019 IDLE with a word handshake: load the shift register, cnt=0, go to SEND; the first byte is valid one cycle after the accepting edge.
REQ-020 SEND, byte handshake, not the last byte: shift the register left by 8, increment cnt, stay in SEND.
REQ-021 SEND, byte handshake on the last byte, with s_axis_tvalid high: load the new word, cnt=0, stay in SEND; this gives continuous output with no bubble.
REQ-022 SEND, byte handshake on the last byte, with s_axis_tvalid low: go to IDLE, cnt=0.
REQ-023 SEND with m_axis_tready low: m_axis_tdata, m_axis_tlast and cnt SHALL hold stable, and no word is accepted.
REQ-024 SHALL sustain one byte per cycle; with NUM_BYTES=1 it SHALL accept one word per cycle and assert tlast on every byte.
REQ-025 SHALL never drop, duplicate or reorder bytes; changes in s_axis_tdata while no word handshake occurs SHALL have no effect.

Reset
REQ-026 While arstn is low, SHALL force: state=IDLE, cnt=0, shift register=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
REQ-027 Reset asserted mid-word SHALL discard the remaining bytes with no partial flush; output stays idle after reset.
REQ-028 After arstn deasserts, s_axis_tready SHALL rise with no extra wait cycles, and the first rising edge may accept a word.

Verification
REQ-029 WORD_WIDTH=24, m_axis_tready=1, word 0xA1B2C3 -> bytes A1, B2, C3 on 3 consecutive cycles starting 1 cycle after accept; tlast only on C3.
REQ-030 WORD_WIDTH=24, words 0x010203 and 0x0A0B0C back-to-back, ready=1 -> 01 02 03 0A 0B 0C with no gap; second word accepted on the edge of the 03 handshake; tlast on 03 and 0C.
REQ-031 WORD_WIDTH=24, 0xA1B2C3, m_axis_tready low for 3 cycles while B2 is presented -> B2 held stable with tvalid=1 and s_axis_tready=0; then C3 follows.
REQ-032 WORD_WIDTH=24, arstn pulsed low while B2 is presented -> tvalid=0 asynchronously, C3 never emitted; next word 0x112233 serializes correctly.
REQ-033 WORD_WIDTH=8, 4 words 0x5A..0x5D, ready=1 -> 4 bytes in 4 consecutive cycles, tlast=1 on every byte.
REQ-034 Randomized tvalid/tready with a scoreboard -> byte stream equals the MSB-first concatenation of accepted words, with tlast count equal to word count.
